adder_result_stage: RTL and testbench
=====================================

# adder_result_stage

Registered output stage directly downstream of the 16-bit ripple adder. It accepts each adder result (sum plus carry, sign, zero, parity and overflow flags) over a valid/ready handshake and buffers it in a small FIFO. It presents results to the consumer in order, and keeps sticky carry/overflow status and a saturating overflow-event counter for software or a controlling FSM.

## Interface
Parameters:
- WIDTH, 16, sum width (matches adder)
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, overflow counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  adder result valid
- in_ready  out  1  stage can accept
- in_sum  in  WIDTH  adder sum
- in_flags  in  5  {carry, sign, zero, parity, overflow} from adder
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_sum  out  WIDTH  head sum
- out_flags  out  5  head flags, same packing as in_flags
- sticky_flags  out  2  {sticky_carry, sticky_overflow}
- ovf_count  out  CNT_W  accepted results with overflow=1, saturating
- clr_sticky  in  1  synchronous clear of sticky_flags and ovf_count
- fill_level  out  $clog2(DEPTH)+1  current occupancy
- flag_err  out  1  sticky flag-consistency error (see Configuration)

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (fill_level != DEPTH). out_valid = (fill_level != 0). Both are driven from registered occupancy only, with no combinational path from in_valid or out_ready.
- Occupancy states: EMPTY (0), PARTIAL, FULL (DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push-without-pop at DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop-without-push at 1.
- Push and pop in the same cycle while PARTIAL: occupancy unchanged, both take effect.
- Full: push is blocked even if a pop occurs that cycle. There is no bypass.
- Empty: there is no pass-through. Data appears only after it is written.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- out_sum/out_flags always show the head entry. When out_valid=0 they hold the last value (don't-care for checking).
- On each push:
  - sticky_carry |= carry; sticky_overflow |= overflow.
  - If overflow=1, ovf_count increments, saturating at 2^CNT_W-1.
- clr_sticky clears sticky_flags and ovf_count to 0.
  - If a push occurs in the same cycle, that push's contribution still applies: sticky bit = that push's flag, ovf_count = that push's overflow bit.
- The stage does not modify flags. Parity convention is 1 for an even number of ones in the sum.

## Timing
- Reset (rst_n low, asynchronous): pointers=0, fill_level=0, out_valid=0, in_ready=1, out_sum=0, out_flags=0, sticky_flags=0, ovf_count=0, flag_err=0.
- Latency: a push at edge N gives out_valid=1 with that data after edge N (visible cycle N+1) if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Reset asserted mid-stream discards all entries and counters immediately. Deassertion is synchronised externally.

## Configuration
- ADDER_RESULT_STAGE_RECHECK_EN defined:
  - On each push the stage recomputes zero (~|in_sum) and parity (~^in_sum).
  - Any mismatch against in_flags sets flag_err, which is sticky until reset or clr_sticky. A push mismatch takes precedence over a simultaneous clear.
- Not defined: no recheck logic is built and flag_err is tied 0.

## Structure
- Package adder_result_pkg:
  - Flag index constants FLAG_CARRY=4, FLAG_SIGN=3, FLAG_ZERO=2, FLAG_PARITY=1, FLAG_OVF=0.
  - A 5-bit packed flags typedef.
  - An entry typedef {sum, flags} parameterised by WIDTH.
- One sub-module, result_fifo: storage, pointers, occupancy, ready/valid.
- Sticky/counter/recheck logic sits in the top level.

## Test plan
- Push sum=16'h3FFF, flags=5'b10011 (BFFF+8000) into an empty FIFO with out_ready=1 → out_valid next cycle, out_sum=3FFF, out_flags=10011, sticky=2'b11, ovf_count=1.
- Hold out_ready=0 and push 5 results → in_ready drops after the 4th push, fill_level=4, the 5th result is not accepted. Pop all 4 → values come out in order and out_valid falls after the 4th pop.
- At fill_level=2, push and pop in the same cycle for 10 cycles → fill_level stays 2 and pointers wrap with order preserved.
- Push 300 results with overflow=1 and CNT_W=8 → ovf_count saturates at 255. Assert clr_sticky together with an overflow push → ovf_count=1, sticky_overflow=1.
- With the macro defined, push sum=16'h0000 with zero=0 → flag_err=1 next cycle. With the macro undefined, the same stimulus → flag_err=0.
- Assert rst_n low mid-stream with fill_level=3 → all outputs return to reset values asynchronously and previously stored entries never appear.

Source files
------------

// File: rtl/adder_result_pkg.sv
// Shared types and flag bit positions for the adder result stage.
package adder_result_pkg;

  localparam int FLAG_CARRY  = 4;
  localparam int FLAG_SIGN   = 3;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_PARITY = 1;
  localparam int FLAG_OVF    = 0;
  localparam int FLAGS_W     = 5;

  typedef logic [FLAGS_W-1:0] flags_t;

  localparam int DEF_WIDTH = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    flags_t               flags;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/result_fifo.sv
// Small in-order result FIFO: storage, wrapping pointers, occupancy FSM and
// registered ready/valid (no combinational path from the handshake inputs).
module result_fifo
  import adder_result_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [WIDTH+FLAGS_W-1:0]   wr_data_i,
  output logic                       wr_fire_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [WIDTH+FLAGS_W-1:0]   rd_data_o,
  output logic [$clog2(DEPTH):0]     fill_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam int DW = WIDTH + FLAGS_W;
  localparam logic [CNT_BITS-1:0] LAST_FREE = CNT_BITS'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  logic [DW-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  occ_state_t          state_q;
  logic                wr_ready_q;
  logic                rd_valid_q;
  logic                push;
  logic                pop;

  assign push = wr_valid_i & wr_ready_q;
  assign pop  = rd_valid_q & rd_ready_i;

  // Storage is cleared on reset so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= OCC_EMPTY;
      wr_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            count_q    <= ONE;
            state_q    <= OCC_PARTIAL;
            rd_valid_q <= 1'b1;
          end
        end
        OCC_PARTIAL: begin
          if (push && !pop) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_FREE) begin
              state_q    <= OCC_FULL;
              wr_ready_q <= 1'b0;
            end
          end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
            if (count_q == ONE) begin
              state_q    <= OCC_EMPTY;
              rd_valid_q <= 1'b0;
            end
          end
        end
        OCC_FULL: begin
          if (pop) begin
            count_q    <= count_q - 1'b1;
            state_q    <= OCC_PARTIAL;
            wr_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign wr_ready_o   = wr_ready_q;
  assign wr_fire_o    = push;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = mem_q[rd_ptr_q];
  assign fill_level_o = count_q;

endmodule

// File: rtl/adder_result_stage.sv
// Output stage behind the ripple adder: result FIFO plus sticky status and
// overflow counter. Define ADDER_RESULT_STAGE_RECHECK_EN to build the zero/parity recheck.
module adder_result_stage
  import adder_result_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic [4:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [4:0]               out_flags,
  output logic [1:0]               sticky_flags,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     flag_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                     push;
  logic [WIDTH+FLAGS_W-1:0] head;
  logic [1:0]               sticky_q, sticky_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid_i   (in_valid),
    .wr_ready_o   (in_ready),
    .wr_data_i    ({in_sum, in_flags}),
    .wr_fire_o    (push),
    .rd_valid_o   (out_valid),
    .rd_ready_i   (out_ready),
    .rd_data_o    (head),
    .fill_level_o (fill_level)
  );

  assign out_sum   = head[FLAGS_W +: WIDTH];
  assign out_flags = head[FLAGS_W-1:0];

  // Clear applies first so a coincident push still leaves its own contribution.
  always_comb begin
    sticky_d = clr_sticky ? 2'b00 : sticky_q;
    cnt_d    = clr_sticky ? '0 : cnt_q;
    if (push) begin
      sticky_d = sticky_d | {in_flags[FLAG_CARRY], in_flags[FLAG_OVF]};
      if (in_flags[FLAG_OVF] && (cnt_d != CNT_MAX)) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign ovf_count    = cnt_q;

`ifdef ADDER_RESULT_STAGE_RECHECK_EN
  logic err_q, err_d, mismatch;

  assign mismatch = push & ((in_flags[FLAG_ZERO] != ~|in_sum) |
                            (in_flags[FLAG_PARITY] != ~^in_sum));

  always_comb begin
    err_d = clr_sticky ? 1'b0 : err_q;
    if (mismatch) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign flag_err = err_q;
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_adder_result_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [4:0]       in_flags = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [4:0]       out_flags;
  logic [1:0]       sticky_flags;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_sticky = 1'b0;
  logic [FW-1:0]    fill_level;
  logic             flag_err;

  always #5 clk = ~clk;

  adder_result_stage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .ovf_count    (ovf_count),
    .clr_sticky   (clr_sticky),
    .fill_level   (fill_level),
    .flag_err     (flag_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {sum, flags} plus status state.
  logic [WIDTH+4:0] mq[$];
  bit m_sc, m_so, m_err;
  int m_cnt;

  typedef struct {
    bit               iv;
    logic [WIDTH-1:0] sum;
    logic [4:0]       flags;
    bit               ordy;
    int               exp_fill;
    bit               exp_in_ready;
    bit               exp_out_valid;
    logic [WIDTH-1:0] exp_head;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] good_flags(input logic [WIDTH-1:0] s, input bit c,
                                            input bit sg, input bit ov);
    return {c, sg, (s == 0), ($countones(s) % 2 == 0), ov};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sc = 0; m_so = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic check_model();
    chk("fill_level", 32'(fill_level), mq.size());
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_sum", 32'(out_sum), 32'(mq[0][WIDTH+4:5]));
      chk("out_flags", 32'(out_flags), 32'(mq[0][4:0]));
    end
    chk("sticky_flags", 32'(sticky_flags), 32'({m_sc, m_so}));
    chk("ovf_count", 32'(ovf_count), m_cnt);
    chk("flag_err", 32'(flag_err), 32'(m_err));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic step(input bit iv, input logic [WIDTH-1:0] s, input logic [4:0] f,
                      input bit ordy, input bit clr);
    bit push, pop;
    in_valid = iv; in_sum = s; in_flags = f; out_ready = ordy; clr_sticky = clr;
    push = iv && (mq.size() < DEPTH);
    pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({s, f});
    if (clr) begin
      m_sc = 0; m_so = 0; m_cnt = 0; m_err = 0;
    end
    if (push) begin
      m_sc = m_sc | f[4];
      m_so = m_so | f[0];
      if (f[0] && m_cnt < CMAX) m_cnt++;
`ifdef ADDER_RESULT_STAGE_RECHECK_EN
      if (f[2] != (s == 0) || f[1] != ($countones(s) % 2 == 0)) m_err = 1;
`endif
    end
    @(negedge clk);
    $display("cyc t=%0t iv=%0b sum=%h fl=%b ordy=%0b clr=%0b push=%0b pop=%0b fill=%0d", $time,
             iv, s, f, ordy, clr, push, pop, fill_level);
    check_model();
  endtask

  initial begin
    logic [WIDTH-1:0] seq [12];
    logic [WIDTH-1:0] s;
    logic [4:0] f;

    for (int i = 0; i < 5; i++) begin
      s = WIDTH'(16'h1111 * (i + 1));
      tbl[i] = '{1'b1, s, good_flags(s, 0, 0, 0), 1'b0, (i < 4) ? i + 1 : 4,
                 (i < 3), 1'b1, 16'h1111};
    end
    for (int i = 0; i < 4; i++) begin
      tbl[5 + i] = '{1'b0, 16'h0, 5'b0, 1'b1, 3 - i, 1'b1, (i < 3),
                     WIDTH'(16'h1111 * (i + 2))};
    end

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    rst_n = 1'b1;

    // Single push into empty FIFO, consumer ready
    step(1, 16'h3FFF, 5'b10011, 1, 0);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_sum", 32'(out_sum), 32'h3FFF);
    chk("t1_out_flags", 32'(out_flags), 32'b10011);
    chk("t1_sticky", 32'(sticky_flags), 32'b11);
    chk("t1_ovf_count", 32'(ovf_count), 1);
    step(0, 16'h0, 5'b0, 1, 1);

    // Fill with consumer stalled, then drain in order
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].iv, tbl[i].sum, tbl[i].flags, tbl[i].ordy, 0);
      chk("tbl_fill", 32'(fill_level), tbl[i].exp_fill);
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].exp_in_ready));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_out_valid));
      if (tbl[i].exp_out_valid) chk("tbl_head", 32'(out_sum), 32'(tbl[i].exp_head));
    end

    // Simultaneous push/pop at fill level 2 across pointer wrap
    for (int i = 0; i < 12; i++) seq[i] = WIDTH'($urandom);
    step(1, seq[0], good_flags(seq[0], 0, 0, 0), 0, 0);
    step(1, seq[1], good_flags(seq[1], 0, 0, 0), 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1, seq[k + 2], good_flags(seq[k + 2], 0, 0, 0), 1, 0);
      chk("pp_fill", 32'(fill_level), 2);
      chk("pp_head", 32'(out_sum), 32'(seq[k + 1]));
    end
    step(0, 16'h0, 5'b0, 1, 0);
    step(0, 16'h0, 5'b0, 1, 0);

    // Overflow counter saturation and clear with coincident push
    for (int i = 0; i < 300; i++) begin
      s = WIDTH'($urandom);
      step(1, s, good_flags(s, 1, 0, 1), 1, 0);
    end
    chk("sat_ovf_count", 32'(ovf_count), CMAX);
    s = 16'h8001;
    step(1, s, good_flags(s, 0, 1, 1), 1, 1);
    chk("clr_ovf_count", 32'(ovf_count), 1);
    chk("clr_sticky", 32'(sticky_flags), 32'b01);
    step(0, 16'h0, 5'b0, 1, 0);

    // Zero flag inconsistent with a zero sum
    step(1, 16'h0000, 5'b00010, 1, 0);
`ifdef ADDER_RESULT_STAGE_RECHECK_EN
    chk("recheck_err", 32'(flag_err), 1);
`else
    chk("recheck_err", 32'(flag_err), 0);
`endif
    step(0, 16'h0, 5'b0, 1, 1);
    chk("recheck_cleared", 32'(flag_err), 0);

    // Asynchronous reset mid-stream with three entries stored
    for (int i = 0; i < 3; i++) begin
      s = WIDTH'(16'hA000 + i);
      step(1, s, good_flags(s, 1, 1, 1), 0, 0);
    end
    chk("pre_rst_fill", 32'(fill_level), 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("arst_out_sum", 32'(out_sum), 0);
    chk("arst_out_flags", 32'(out_flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 16'h0, 5'b0, 1, 0);
    s = 16'h0F0F;
    step(1, s, good_flags(s, 0, 0, 0), 0, 0);
    chk("post_rst_head", 32'(out_sum), 32'h0F0F);
    step(0, 16'h0, 5'b0, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s = WIDTH'($urandom);
      if ($urandom_range(0, 3) != 0) f = good_flags(s, $urandom_range(0, 1) == 1,
                                                    $urandom_range(0, 1) == 1,
                                                    $urandom_range(0, 1) == 1);
      else f = 5'($urandom);
      step($urandom_range(0, 3) != 0, s, f, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
